jk_ubus_slave_mem: RTL
======================

# jk_ubus_slave_mem

Parametrised, synthesisable UBUS slave responder with an internal byte-addressable memory, programmable wait-state insertion, address-window decode with error response, and an optional read-only mode. It sits on the UBUS as a slave endpoint: as a DUT target for the slave VIP agent, or as a real memory-mapped peripheral shell. It generalises the fixed 16-bit/8-bit slave pin set:

- Address and data widths are parameters.
- The shared `data` bus is split into separate in, out and enable signals.
- Response timing is owned by an internal state machine.

## Interface
Parameters:
- `ADDR_W`, 16: address width.
- `DATA_W`, 8: data bus width, bits per beat. Memory word width equals `DATA_W`.
- `MEM_DEPTH`, 256: number of memory words. Range is 1 to 2^`ADDR_W`.
- `BASE_ADDR`, 0: first decoded address.
- `WAIT_CYCLES`, 0: wait cycles inserted before every beat. Range is 0 to 15.
- `READ_ONLY`, 0: when 1, all writes get an error response and the memory is not modified.

Ports:
- `clk` input 1: single clock. All logic is on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `addr` input `ADDR_W`: start address. Valid in the address phase.
- `size` input 2: burst length is 1 << `size` beats (1, 2, 4 or 8).
- `read` input 1: address-phase read request.
- `write` input 1: address-phase write request.
- `bip` input 1: burst in progress. Driven high by the master on every beat except the last.
- `data_in` input `DATA_W`: write data from the master.
- `data_out` output `DATA_W`: read data to the master.
- `data_oe` output 1: slave drives the data bus this cycle.
- `wait_state` output 1: the current beat is stalled.
- `error` output 1: the current beat completes with an error.
- `protocol_err` output 1: sticky master protocol violation flag. Cleared only by `reset`.

## Operation
- States: `IDLE`, `WAIT`, `BEAT`.
- `IDLE`: a cycle with exactly one of `read`/`write` high is the address phase. On that cycle:
  - Latch `addr`, direction and beat count.
  - Compute `hit` = (`addr` >= `BASE_ADDR`) and (`addr` + beats − 1 <= `BASE_ADDR` + `MEM_DEPTH` − 1). Evaluate at `ADDR_W`+1 bits so no overflow can occur.
  - Latch `err_xfer` = !`hit` or (write and `READ_ONLY`).
  - Go to `WAIT` if `WAIT_CYCLES` > 0, else to `BEAT`.
- `read` and `write` high together: `protocol_err` is set, no transfer starts, and the block stays in `IDLE`.
- `WAIT`: `wait_state` = 1 for `WAIT_CYCLES` cycles, counted down by a 4-bit counter. Then go to `BEAT`.
- `BEAT`: `wait_state` = 0 and the beat completes this cycle.
  - Write with !`err_xfer`: `mem[addr − BASE_ADDR + beat_idx]` <= `data_in`.
  - Read: `data_oe` = 1. `data_out` = memory word, or 0 if `err_xfer`.
  - `error` = `err_xfer`.
  - If this is not the last beat: increment `beat_idx` and go to `WAIT` or `BEAT`.
  - If this is the last beat: go to `IDLE`.
- The beat count is owned by the slave. If `bip` on a completed beat disagrees with (`beat_idx` != beats − 1), `protocol_err` is set and the slave still finishes its own count.
- Address-phase requests seen while not in `IDLE` are ignored.
- Memory is not reset. Its contents are undefined until written.

## Timing
- Reset values:
  - `data_out` = 0, `data_oe` = 0, `wait_state` = 0, `error` = 0, `protocol_err` = 0.
  - State `IDLE`, `beat_idx` = 0.
- All outputs are registered, changing only on `clk` edges or on `reset` assertion.
- Address phase at cycle T:
  - First beat completes at T+1+`WAIT_CYCLES`.
  - Beat k completes at T+1+`WAIT_CYCLES` + k·(`WAIT_CYCLES`+1).
- With `WAIT_CYCLES`=0 the slave completes one beat per cycle and `wait_state` stays low.
- A new address phase is accepted on the cycle after the last beat completes, i.e. back-to-back with no idle cycle.
- Write data is sampled only on completing cycles, never on wait cycles.
- `data_oe` and `error` are high only on completing cycles.
- Reset mid-burst: immediate abort. Outputs go to reset values. Beats already written stay in memory.

## Test plan
- `WAIT_CYCLES`=0, `BASE_ADDR`=0x100: write `size`=2 at 0x100 with data 0x11,0x22,0x33,0x44 -> 4 consecutive completing cycles with `error`=0. Then read 0x100 `size`=2 -> `data_out` 0x11,0x22,0x33,0x44 with `data_oe`=1 on cycles T+1..T+4.
- `WAIT_CYCLES`=2: read `size`=1 -> pattern `wait_state` 1,1,0,1,1,0 and data on the 0 cycles only.
- Out of range: `MEM_DEPTH`=256, `BASE_ADDR`=0x100, write `size`=3 at 0x1FC (crosses the top) -> all 8 beats have `error`=1 and memory is unchanged. Read at 0x0FF -> `error`=1, `data_out`=0.
- `READ_ONLY`=1: write 0xAA at 0x100 -> `error`=1. A following read returns the prior contents with `error`=0.
- Protocol: `read`=`write`=1 -> `protocol_err`=1, no beats. Separately, `bip`=0 on beat 0 of a 4-beat burst -> `protocol_err`=1 and the slave still completes 4 beats.
- Assert `reset` during beat 2 of a 4-beat write -> all outputs 0 and state `IDLE`. Beats 0–1 are written, beats 2–3 are not. A next transfer works normally.

Source files
------------

// File: rtl/jk_ubus_slave_mem.sv
// UBUS slave responder: internal memory, programmable wait states, window decode, optional read-only mode.
// Latency: first beat completes WAIT_CYCLES+1 cycles after the address phase, then one beat per WAIT_CYCLES+1 cycles.
// Backpressure: wait_state stalls each beat for WAIT_CYCLES cycles; the slave owns the beat count, and the master cannot stall.
//
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-high reset
//   addr, size          - start address and burst length code (1 << size beats), sampled in the address phase
//   read, write         - address-phase request; both high is a protocol violation
//   bip                 - burst in progress from the master; checked against the slave's own beat count
//   data_in             - write data, sampled only on completing beats
//   data_out, data_oe   - read data and bus-drive enable (high only on completing read beats)
//   wait_state, error   - beat stall indicator and per-beat error response
//   protocol_err        - sticky master protocol violation flag, cleared only by reset
module jk_ubus_slave_mem #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int MEM_DEPTH   = 256,
  parameter int BASE_ADDR   = 0,
  parameter int WAIT_CYCLES = 0,
  parameter int READ_ONLY   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  input  logic              read,
  input  logic              write,
  input  logic              bip,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic              wait_state,
  output logic              error,
  output logic              protocol_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_BEAT = 2'd2
  } state_t;

  localparam int             AW1       = ADDR_W + 1;
  localparam int             IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [AW1-1:0] LO_X      = AW1'(BASE_ADDR);
  localparam logic [AW1-1:0] HI_X      = AW1'(BASE_ADDR + MEM_DEPTH - 1);
  localparam logic [3:0]     WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic           HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic           RO        = (READ_ONLY != 0);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  offset_q, offset_d;
  logic [2:0]        last_idx_q, last_idx_d;
  logic [2:0]        beat_idx_q, beat_idx_d;
  logic              is_write_q, is_write_d;
  logic              err_xfer_q, err_xfer_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              protocol_err_q, protocol_err_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_oe_q, data_oe_d;
  logic              wait_state_q, wait_state_d;
  logic              error_q, error_d;

  // Address-phase decode, evaluated one bit wider than the bus so the end
  // address of a burst near the top of the address space cannot wrap.
  logic [2:0]       last_idx_in;
  logic [AW1-1:0]   addr_x;
  logic [AW1-1:0]   end_x;
  logic             hit;
  logic             beat_last;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;

  assign last_idx_in = 3'((4'd1 << size) - 4'd1);
  assign addr_x      = {1'b0, addr};
  assign end_x       = addr_x + AW1'(last_idx_in);
  assign hit         = (addr_x >= LO_X) && (end_x <= HI_X);
  assign beat_last   = (beat_idx_q == last_idx_q);
  assign wr_idx      = offset_q + IDX_W'(beat_idx_q);

  always_comb begin
    state_d        = state_q;
    offset_d       = offset_q;
    last_idx_d     = last_idx_q;
    beat_idx_d     = beat_idx_q;
    is_write_d     = is_write_q;
    err_xfer_d     = err_xfer_q;
    wait_cnt_d     = wait_cnt_q;
    protocol_err_d = protocol_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (read && write) begin
          protocol_err_d = 1'b1;
        end else if (read || write) begin
          // Modular subtraction at index width yields the true offset whenever hit is set.
          offset_d   = IDX_W'(addr) - IDX_W'(BASE_ADDR);
          last_idx_d = last_idx_in;
          beat_idx_d = 3'd0;
          is_write_d = write;
          err_xfer_d = !hit || (write && RO);
          wait_cnt_d = WAIT_INIT;
          state_d    = HAS_WAIT ? ST_WAIT : ST_BEAT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = ST_BEAT;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      ST_BEAT: begin
        // The master should hold bip high on every beat except the last.
        if (bip == beat_last) begin
          protocol_err_d = 1'b1;
        end
        if (beat_last) begin
          state_d = ST_IDLE;
        end else begin
          beat_idx_d = beat_idx_q + 3'd1;
          wait_cnt_d = WAIT_INIT;
          state_d    = HAS_WAIT ? ST_WAIT : ST_BEAT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    rd_idx       = offset_d + IDX_W'(beat_idx_d);
    wait_state_d = (state_d == ST_WAIT);
    data_oe_d    = (state_d == ST_BEAT) && !is_write_d;
    error_d      = (state_d == ST_BEAT) && err_xfer_d;
    data_out_d   = '0;
    if ((state_d == ST_BEAT) && !is_write_d && !err_xfer_d) begin
      data_out_d = mem[rd_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      offset_q       <= '0;
      last_idx_q     <= 3'd0;
      beat_idx_q     <= 3'd0;
      is_write_q     <= 1'b0;
      err_xfer_q     <= 1'b0;
      wait_cnt_q     <= 4'd0;
      protocol_err_q <= 1'b0;
      data_out_q     <= '0;
      data_oe_q      <= 1'b0;
      wait_state_q   <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      offset_q       <= offset_d;
      last_idx_q     <= last_idx_d;
      beat_idx_q     <= beat_idx_d;
      is_write_q     <= is_write_d;
      err_xfer_q     <= err_xfer_d;
      wait_cnt_q     <= wait_cnt_d;
      protocol_err_q <= protocol_err_d;
      data_out_q     <= data_out_d;
      data_oe_q      <= data_oe_d;
      wait_state_q   <= wait_state_d;
      error_q        <= error_d;
    end
  end

  // Memory has no reset; while reset is high the state is IDLE, so nothing is written.
  always_ff @(posedge clk) begin
    if ((state_q == ST_BEAT) && is_write_q && !err_xfer_q) begin
      mem[wr_idx] <= data_in;
    end
  end

  assign data_out     = data_out_q;
  assign data_oe      = data_oe_q;
  assign wait_state   = wait_state_q;
  assign error        = error_q;
  assign protocol_err = protocol_err_q;

endmodule
